// File: rtl/ec_rec_rd_pkg.sv
// -----------------------------------------------------------------------------
// enc_defines
//   Shared definitions for the entropy-coder reconstruction read path:
//   the readout FSM state encodings, the reconstruction address width and
//   the luma/chroma boundary inside one LCU's word address space.
// -----------------------------------------------------------------------------
package enc_defines;

    // Word address width towards the TLB / reconstruction memory.
    localparam int unsigned EC_ADDR_W  = 9;

    // Addresses below this value are luma words, at or above are chroma.
    localparam int unsigned LUMA_WORDS = 256;

    // Readout FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_t;

    // True when a word address falls in the chroma part of the LCU.
    function automatic logic is_chroma(input logic [EC_ADDR_W-1:0] addr);
        return ({23'd0, addr} >= LUMA_WORDS);
    endfunction

endpackage

// File: rtl/ec_rec_fifo.sv
// -----------------------------------------------------------------------------
// ec_rec_fifo
//   Two-entry FIFO between the reconstruction memory return path and the
//   downstream consumer. Push and pop may happen in the same cycle.
//
// Ports
//   clk       in   clock
//   rst_n     in   asynchronous active-low reset
//   push      in   write push_dat at the tail
//   push_dat  in   DAT_WIDTH word to store
//   pop       in   drop the head entry (only while count != 0)
//   head_dat  out  DAT_WIDTH head entry
//   count     out  number of stored entries, 0..2
// -----------------------------------------------------------------------------
module ec_rec_fifo #(
    parameter int DAT_WIDTH = 128
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic [DAT_WIDTH-1:0] push_dat,
    input  logic                 pop,
    output logic [DAT_WIDTH-1:0] head_dat,
    output logic [1:0]           count
);

    logic [DAT_WIDTH-1:0] mem_q [2];
    logic                 wr_ptr_q;
    logic                 rd_ptr_q;
    logic [1:0]           cnt_q;

    // NOTE: non-blocking assignments for every register so all flops update
    // together from the values sampled at the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the two storage words are reset as well, so the head word
            // (and hence dat_o) reads zero while in reset; this only costs two
            // small registers, unlike resetting a real memory array.
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_dat;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign head_dat = mem_q[rd_ptr_q];
    assign count    = cnt_q;

    // The issuing side only requests a read when a slot is guaranteed.
    a_no_push_on_full: assert property (
        @(posedge clk) disable iff (!rst_n) !(push && (cnt_q == 2'd2))
    );
    a_no_pop_on_empty: assert property (
        @(posedge clk) disable iff (!rst_n) !(pop && (cnt_q == 2'd0))
    );

endmodule

// File: rtl/ec_rec_rd.sv
// -----------------------------------------------------------------------------
// ec_rec_rd
//   Reads one LCU (ADDR_NUM words) out of the banked reconstruction memory.
//   An issue counter walks the word addresses; the TLB returns the bank and
//   ping-pong half for the current address in the same cycle. One cycle after
//   each read strobe the returned 4-bank line is narrowed to the selected bank
//   and pushed into a 2-entry FIFO whose head drives the val/rdy output.
//
// Ports
//   clk            in   clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   start_i        in   one-cycle pulse, begin LCU readout (ignored unless idle)
//   busy_o         out  high from accepted start until done
//   done_o         out  one-cycle pulse after the last word is transferred
//   ec_addr_o      out  word address to the TLB (>255 is chroma)
//   ec_bank_i      in   TLB bank for ec_addr_o, same cycle
//   ec_cbank_i     in   TLB ping-pong half, same cycle
//   mem_rd_ena_o   out  memory read strobe
//   mem_rd_sel_o   out  {ec_cbank_i, ec_bank_i} at issue
//   mem_rd_addr_o  out  ec_addr_o at issue
//   mem_rd_dat_i   in   4 banks concatenated, bank 0 in LSBs, one cycle later
//   dat_val_o      out  output word valid
//   dat_o          out  output word
//   dat_rdy_i      in   downstream ready, transfer on val & rdy
// -----------------------------------------------------------------------------
module ec_rec_rd
    import enc_defines::*;
#(
    parameter int DAT_WIDTH = 128,
    parameter int ADDR_NUM  = 384
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [8:0]             ec_addr_o,
    input  logic [1:0]             ec_bank_i,
    input  logic                   ec_cbank_i,
    output logic                   mem_rd_ena_o,
    output logic [2:0]             mem_rd_sel_o,
    output logic [8:0]             mem_rd_addr_o,
    input  logic [4*DAT_WIDTH-1:0] mem_rd_dat_i,
    output logic                   dat_val_o,
    output logic [DAT_WIDTH-1:0]   dat_o,
    input  logic                   dat_rdy_i
);

    localparam logic [8:0] LAST_ADDR = 9'(ADDR_NUM - 1);

    rd_state_t            state_q;
    logic [8:0]           iss_addr_q;   // next word address to issue
    logic [8:0]           xfer_cnt_q;   // words handed downstream this LCU
    logic                 rd_pend_q;    // a read was issued last cycle
    logic [1:0]           rd_bank_q;    // bank of that read
    logic                 busy_q;
    logic                 done_q;

    logic [1:0]           fifo_cnt;
    logic [DAT_WIDTH-1:0] fifo_head;
    logic [DAT_WIDTH-1:0] ret_dat;
    logic [2:0]           credit_used;
    logic                 pop;
    logic                 issue;
    logic                 last_xfer;

    assign dat_val_o = (fifo_cnt != 2'd0);
    assign dat_o     = fifo_head;
    assign pop       = dat_val_o & dat_rdy_i;

    // Buffered words plus the read in flight, after this cycle's pop has
    // freed its slot. Counting the pop lets a new read go out in the same
    // cycle a word leaves, which is what sustains one word per cycle.
    assign credit_used = {1'b0, fifo_cnt} + {2'b00, rd_pend_q} - {2'b00, pop};
    assign issue       = (state_q == ST_RUN) && (credit_used < 3'd2);
    assign last_xfer   = pop && (xfer_cnt_q == LAST_ADDR);

    // Returned line narrowed to the bank captured at issue.
    assign ret_dat = mem_rd_dat_i[DAT_WIDTH*int'(rd_bank_q) +: DAT_WIDTH];

    // NOTE: every output of this block gets a default before the condition,
    // otherwise the idle-cycle values would be held in inferred latches.
    always_comb begin
        mem_rd_ena_o  = 1'b0;
        mem_rd_sel_o  = 3'd0;
        mem_rd_addr_o = 9'd0;
        if (issue) begin
            mem_rd_ena_o  = 1'b1;
            mem_rd_sel_o  = {ec_cbank_i, ec_bank_i};
            mem_rd_addr_o = iss_addr_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            iss_addr_q <= 9'd0;
            xfer_cnt_q <= 9'd0;
            rd_pend_q  <= 1'b0;
            rd_bank_q  <= 2'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            rd_pend_q <= issue;
            if (issue) begin
                rd_bank_q <= ec_bank_i;
            end
            if (pop) begin
                xfer_cnt_q <= last_xfer ? 9'd0 : xfer_cnt_q + 9'd1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_q    <= ST_RUN;
                        iss_addr_q <= 9'd0;
                        xfer_cnt_q <= 9'd0;
                        busy_q     <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (issue) begin
                        // Wrap to 0 after the last address so the next LCU
                        // continues seamlessly from 0.
                        if (iss_addr_q == LAST_ADDR) begin
                            iss_addr_q <= 9'd0;
                            state_q    <= ST_DRAIN;
                        end else begin
                            iss_addr_q <= iss_addr_q + 9'd1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (last_xfer) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign ec_addr_o = iss_addr_q;

    ec_rec_fifo #(
        .DAT_WIDTH (DAT_WIDTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (rd_pend_q),
        .push_dat (ret_dat),
        .pop      (pop),
        .head_dat (fifo_head),
        .count    (fifo_cnt)
    );

endmodule

// File: tb/tb_ec_rec_rd.sv
// -----------------------------------------------------------------------------
// tb_ec_rec_rd
//   Scoreboard bench for ec_rec_rd. Starting an LCU pushes the expected issue
//   addresses/selects and the expected output words into queues; a monitor on
//   the falling edge pops and compares whenever the DUT issues a read or
//   transfers a word. The memory model returns a full 4-bank line whose words
//   encode {half, bank, address}, so a wrong bank or half shows in the data.
// -----------------------------------------------------------------------------
module tb_ec_rec_rd;
    import enc_defines::*;

    localparam int DW = 128;
    localparam int AN = 384;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start_i;
    logic              busy_o;
    logic              done_o;
    logic [8:0]        ec_addr_o;
    logic [1:0]        ec_bank_i;
    logic              ec_cbank_i;
    logic              mem_rd_ena_o;
    logic [2:0]        mem_rd_sel_o;
    logic [8:0]        mem_rd_addr_o;
    logic [4*DW-1:0]   mem_rd_dat_i = '0;
    logic              dat_val_o;
    logic [DW-1:0]     dat_o;
    logic              dat_rdy_i;

    ec_rec_rd #(
        .DAT_WIDTH (DW),
        .ADDR_NUM  (AN)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .ec_addr_o     (ec_addr_o),
        .ec_bank_i     (ec_bank_i),
        .ec_cbank_i    (ec_cbank_i),
        .mem_rd_ena_o  (mem_rd_ena_o),
        .mem_rd_sel_o  (mem_rd_sel_o),
        .mem_rd_addr_o (mem_rd_addr_o),
        .mem_rd_dat_i  (mem_rd_dat_i),
        .dat_val_o     (dat_val_o),
        .dat_o         (dat_o),
        .dat_rdy_i     (dat_rdy_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    function automatic logic [1:0] bank_of(input logic [8:0] a);
        return is_chroma(a) ? 2'd3 : a[1:0];
    endfunction

    function automatic logic [DW-1:0] word_of(input logic h, input logic [1:0] b,
                                              input logic [8:0] a);
        return {16'hC0DE, 15'd0, h, 30'd0, b, 23'd0, a, 32'h5A5A_0000 ^ {23'd0, a}};
    endfunction

    function automatic logic [4*DW-1:0] line_of(input logic h, input logic [8:0] a);
        logic [4*DW-1:0] l;
        for (int b = 0; b < 4; b++) l[b*DW +: DW] = word_of(h, 2'(b), a);
        return l;
    endfunction

    // TLB: combinational bank lookup for the current address.
    assign ec_bank_i = bank_of(ec_addr_o);

    // Memory: line for {half, address} appears the cycle after the strobe.
    always @(posedge clk)
        if (mem_rd_ena_o) mem_rd_dat_i <= line_of(mem_rd_sel_o[2], mem_rd_addr_o);

    // ---------------- scoreboard ----------------
    logic [DW-1:0] exp_q[$];
    logic [9:0]    iss_q[$];
    int            checks = 0;
    int            failures = 0;
    int            n_iss = 0;
    int            n_xfer = 0;
    int            done_seen = 0;
    int            first_val_cyc = -1;
    int            used_words;
    logic          stall_prev = 1'b0;
    logic [DW-1:0] stall_dat;
    logic [DW-1:0] exp_w;
    logic [9:0]    exp_i;
    bit            toggle_rdy = 1'b0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            n_iss      = 0;
            n_xfer     = 0;
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_valid_held", dat_val_o, 1);
                check("stall_dat_held", dat_o, stall_dat);
            end
            if (mem_rd_ena_o) begin
                used_words = n_iss - n_xfer - ((dat_val_o && dat_rdy_i) ? 1 : 0);
                check("issue_credit", used_words < 2, 1);
                check("issue_expected", iss_q.size() > 0, 1);
                if (iss_q.size() > 0) begin
                    exp_i = iss_q.pop_front();
                    check("issue_addr", mem_rd_addr_o, exp_i[8:0]);
                    check("issue_ec_addr", ec_addr_o, exp_i[8:0]);
                    check("issue_sel", mem_rd_sel_o, {exp_i[9], bank_of(exp_i[8:0])});
                end
                n_iss++;
            end
            if (dat_val_o && dat_rdy_i) begin
                check("word_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    exp_w = exp_q.pop_front();
                    check("word_data", dat_o, exp_w);
                end
                n_xfer++;
            end
            if (dat_val_o && first_val_cyc < 0) first_val_cyc = cyc;
            if (done_o) done_seen++;
            stall_prev = dat_val_o && !dat_rdy_i;
            stall_dat  = dat_o;
        end
    end

    // Downstream ready: steady high, or alternating every cycle.
    initial begin
        dat_rdy_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            dat_rdy_i = toggle_rdy ? ~dat_rdy_i : 1'b1;
        end
    end

    // ---------------- stimulus helpers ----------------
    // Queue the expectations for one LCU and pulse start; the pulse is
    // sampled by the next rising edge, whose cycle number is returned.
    task automatic start_lcu(input logic h, output int s);
        for (int a = 0; a < AN; a++) begin
            exp_q.push_back(word_of(h, bank_of(9'(a)), 9'(a)));
            iss_q.push_back({h, 9'(a)});
        end
        ec_cbank_i    = h;
        first_val_cyc = -1;
        s             = cyc + 1;
        start_i       = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done(output int dcyc);
        dcyc = -1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done_o) begin
                dcyc = cyc;
                check("busy_low_with_done", busy_o, 0);
                break;
            end
        end
        check("done_within_budget", dcyc >= 0, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_done"}, done_o, 0);
        check({tag, "_rd_ena"}, mem_rd_ena_o, 0);
        check({tag, "_dat_val"}, dat_val_o, 0);
        check({tag, "_ec_addr"}, ec_addr_o, 0);
        check({tag, "_rd_sel"}, mem_rd_sel_o, 0);
        check({tag, "_rd_addr"}, mem_rd_addr_o, 0);
        check({tag, "_dat"}, dat_o, 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int s;
        int s2;
        int d;
        int base;

        rst_n      = 1'b1;
        start_i    = 1'b0;
        ec_cbank_i = 1'b0;
        #1 rst_n = 1'b0;
        #2 check_reset_outputs("por");
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // LCU A: full rate, half 0.
        @(posedge clk); #1;
        start_lcu(1'b0, s);
        check("A_busy_after_start", busy_o, 1);
        wait_done(d);
        check("A_first_valid_cycle", first_val_cyc, s + 2);
        check("A_done_cycle", d, s + 386);
        repeat (4) @(negedge clk);
        check("A_done_once", done_seen, 1);
        check("A_word_count", n_xfer, AN);
        check("A_queue_empty", exp_q.size(), 0);

        // LCU B: ready toggling, half 1, stray start mid-LCU.
        toggle_rdy = 1'b1;
        @(posedge clk); #1;
        start_lcu(1'b1, s);
        repeat (48) @(posedge clk);
        #1;
        check("B_busy_at_stray_start", busy_o, 1);
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        wait_done(d);
        toggle_rdy = 1'b0;
        repeat (4) @(negedge clk);
        check("B_done_once", done_seen, 2);
        check("B_word_count", n_xfer, 2 * AN);
        check("B_queue_empty", exp_q.size(), 0);
        check("B_issue_queue_empty", iss_q.size(), 0);

        // LCU D then E back-to-back, start in D's done cycle, half flips.
        @(posedge clk); #1;
        start_lcu(1'b0, s);
        wait_done(d);
        check("D_done_cycle", d, s + 386);
        start_lcu(1'b1, s2);
        check("E_busy_no_gap", busy_o, 1);
        wait_done(d);
        check("E_first_valid_cycle", first_val_cyc, s2 + 2);
        check("E_done_cycle", d, s2 + 386);
        repeat (4) @(negedge clk);
        check("E_done_count", done_seen, 4);
        check("E_queue_empty", exp_q.size(), 0);

        // LCU F: reset after ~100 words, then LCU G restarts from address 0.
        @(posedge clk); #1;
        start_lcu(1'b1, s);
        base = n_xfer;
        for (int i = 0; i < 2000 && n_xfer < base + 100; i++) @(negedge clk);
        check("F_reached_word_100", n_xfer >= base + 100, 1);
        rst_n = 1'b0;
        #1 check_reset_outputs("mid");
        exp_q.delete();
        iss_q.delete();
        repeat (2) @(posedge clk);
        #1 check_reset_outputs("mid_hold");
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_reset_no_stale_word", dat_val_o, 0);
        check("post_reset_addr_zero", ec_addr_o, 0);

        @(posedge clk); #1;
        start_lcu(1'b0, s);
        wait_done(d);
        check("G_first_valid_cycle", first_val_cyc, s + 2);
        check("G_done_cycle", d, s + 386);
        repeat (4) @(negedge clk);
        check("G_done_count", done_seen, 5);
        check("G_word_count", n_xfer, AN);
        check("G_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
